// File: rtl/regfile_access_ctrl_pkg.sv
// Shared constants, FSM encoding and helpers for the register-file access controller.
package regfile_access_ctrl_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // One-hot mask for a register index; x0 and disabled requests give an empty mask.
  function automatic logic [NREG-1:0] reg_mask(input logic en, input logic [AW-1:0] idx);
    logic [NREG-1:0] one_v;
    one_v = {{(NREG-1){1'b0}}, 1'b1};
    if (en && (idx != {AW{1'b0}})) begin
      return one_v << idx;
    end else begin
      return {NREG{1'b0}};
    end
  endfunction

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Request, response and writeback channels between the control FSM and the access controller.
interface regfile_access_ctrl_if;
  import regfile_access_ctrl_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [AW-1:0]   req_rs1;
  logic [AW-1:0]   req_rs2;
  logic [AW-1:0]   req_rd;
  logic            req_wr;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_op1;
  logic [XLEN-1:0] rsp_op2;
  logic            wb_valid;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            wb_err;

  modport master (
    output req_valid, req_rs1, req_rs2, req_rd, req_wr, rsp_ready, wb_valid, wb_rd, wb_data,
    input  req_ready, rsp_valid, rsp_op1, rsp_op2, wb_err
  );

  modport slave (
    input  req_valid, req_rs1, req_rs2, req_rd, req_wr, rsp_ready, wb_valid, wb_rd, wb_data,
    output req_ready, rsp_valid, rsp_op1, rsp_op2, wb_err
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy vector for registers with an outstanding writeback; x0 is never busy.
module regfile_scoreboard
  import regfile_access_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_idx,
  input  logic [AW-1:0] src1_idx,
  input  logic [AW-1:0] src2_idx,
  input  logic [AW-1:0] dst_idx,
  output logic          src1_busy,
  output logic          src2_busy,
  output logic          dst_busy,
  output logic          clr_busy
);

  logic [NREG-1:0] busy_r;
  logic [NREG-1:0] busy_next_s;

  // Clear first, then set, so a same-cycle set on the same register wins.
  always_comb begin
    busy_next_s = (busy_r & ~reg_mask(clr_en, clr_idx)) | reg_mask(set_en, set_idx);
  end

  // Busy vector register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r <= {NREG{1'b0}};
    end else begin
      busy_r <= busy_next_s;
    end
  end

  assign src1_busy = busy_r[src1_idx];
  assign src2_busy = busy_r[src2_idx];
  assign dst_busy  = busy_r[dst_idx];
  assign clr_busy  = busy_r[clr_idx];

endmodule

// File: rtl/regfile_access_ctrl.sv
// Operand fetch sequencer for the register file with writeback hazard scoreboard and forwarding.
module regfile_access_ctrl
  import regfile_access_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  regfile_access_ctrl_if.slave  bus,
  output logic [AW-1:0]         rf_a1,
  output logic [AW-1:0]         rf_a2,
  output logic [AW-1:0]         rf_a3,
  output logic [XLEN-1:0]       rf_wd3,
  output logic                  rf_we,
  input  logic [XLEN-1:0]       rf_rd1,
  input  logic [XLEN-1:0]       rf_rd2
);

  state_e          state_r;
  state_e          state_next_s;
  logic [AW-1:0]   rs1_r;
  logic [AW-1:0]   rs2_r;
  logic [XLEN-1:0] op1_r;
  logic [XLEN-1:0] op2_r;
  logic            wb_err_r;
  logic            req_ready_s;
  logic            rsp_valid_s;
  logic            accept_s;
  logic            fwd1_s;
  logic            fwd2_s;
  logic            src1_busy_s;
  logic            src2_busy_s;
  logic            dst_busy_s;
  logic            wb_busy_s;

  regfile_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en    (accept_s & bus.req_wr),
    .set_idx   (bus.req_rd),
    .clr_en    (bus.wb_valid),
    .clr_idx   (bus.wb_rd),
    .src1_idx  (bus.req_rs1),
    .src2_idx  (bus.req_rs2),
    .dst_idx   (bus.req_rd),
    .src1_busy (src1_busy_s),
    .src2_busy (src2_busy_s),
    .dst_busy  (dst_busy_s),
    .clr_busy  (wb_busy_s)
  );

  assign accept_s = bus.req_valid & req_ready_s;
  assign fwd1_s   = bus.wb_valid && (bus.wb_rd == rs1_r) && (rs1_r != {AW{1'b0}});
  assign fwd2_s   = bus.wb_valid && (bus.wb_rd == rs2_r) && (rs2_r != {AW{1'b0}});

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_next_s = ST_READ;
        else          state_next_s = ST_IDLE;
      end
      ST_READ: state_next_s = ST_RESP;
      ST_RESP: begin
        if (bus.rsp_ready) state_next_s = ST_IDLE;
        else               state_next_s = ST_RESP;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM outputs; the hazard check looks only at the registered busy bits.
  always_comb begin
    req_ready_s = 1'b0;
    rsp_valid_s = 1'b0;
    case (state_r)
      ST_IDLE: req_ready_s = !(src1_busy_s || src2_busy_s || (bus.req_wr && dst_busy_s));
      ST_RESP: rsp_valid_s = 1'b1;
      default: begin
        req_ready_s = 1'b0;
        rsp_valid_s = 1'b0;
      end
    endcase
  end

  // Source index latch, operand capture with writeback forwarding, and writeback error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs1_r    <= {AW{1'b0}};
      rs2_r    <= {AW{1'b0}};
      op1_r    <= {XLEN{1'b0}};
      op2_r    <= {XLEN{1'b0}};
      wb_err_r <= 1'b0;
    end else begin
      if (accept_s) begin
        rs1_r <= bus.req_rs1;
        rs2_r <= bus.req_rs2;
      end
      if (state_r == ST_READ) begin
        op1_r <= fwd1_s ? bus.wb_data : rf_rd1;
        op2_r <= fwd2_s ? bus.wb_data : rf_rd2;
      end
      wb_err_r <= bus.wb_valid && (bus.wb_rd != {AW{1'b0}}) && !wb_busy_s;
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_s;
  assign bus.rsp_op1   = op1_r;
  assign bus.rsp_op2   = op2_r;
  assign bus.wb_err    = wb_err_r;

  assign rf_a1  = rs1_r;
  assign rf_a2  = rs2_r;
  assign rf_a3  = bus.wb_rd;
  assign rf_wd3 = bus.wb_data;
  assign rf_we  = bus.wb_valid;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a behavioural register file attached.
module tb_regfile_access_ctrl;
  import regfile_access_ctrl_pkg::*;

  logic            clk;
  logic            rst;
  logic [AW-1:0]   rf_a1, rf_a2, rf_a3;
  logic [XLEN-1:0] rf_wd3, rf_rd1, rf_rd2;
  logic            rf_we;
  logic [31:0]     rf_mem [32];
  int              tests = 0;
  int              fails = 0;

  regfile_access_ctrl_if bus ();

  regfile_access_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .rf_a1  (rf_a1),
    .rf_a2  (rf_a2),
    .rf_a3  (rf_a3),
    .rf_wd3 (rf_wd3),
    .rf_we  (rf_we),
    .rf_rd1 (rf_rd1),
    .rf_rd2 (rf_rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= 32'h0;
    end else if (rf_we && rf_a3 != 5'd0) begin
      rf_mem[rf_a3] <= rf_wd3;
    end
  end

  assign rf_rd1 = rst ? rf_mem[rf_a1] : 32'h0;
  assign rf_rd2 = rst ? rf_mem[rf_a2] : 32'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_wb(input logic [4:0] rd, input logic [31:0] data);
    bus.wb_valid = 1'b1; bus.wb_rd = rd; bus.wb_data = data;
    tick();
    bus.wb_valid = 1'b0;
  endtask

  task automatic run_req(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic wr, output logic [31:0] o1, output logic [31:0] o2,
                         output bit ok);
    int n;
    ok = 1'b1; o1 = 32'h0; o2 = 32'h0;
    bus.req_rs1 = rs1; bus.req_rs2 = rs2; bus.req_rd = rd; bus.req_wr = wr;
    bus.req_valid = 1'b1;
    #1;
    n = 0;
    while (!bus.req_ready && n < 100) begin
      tick();
      n++;
    end
    if (!bus.req_ready) begin
      ok = 1'b0;
    end else begin
      tick();
      bus.req_valid = 1'b0;
      tick();
      if (bus.rsp_valid !== 1'b1) ok = 1'b0;
      o1 = bus.rsp_op1; o2 = bus.rsp_op2;
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
    end
    bus.req_valid = 1'b0; bus.req_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.req_valid = 1'b0; bus.req_rs1 = 5'd0; bus.req_rs2 = 5'd0; bus.req_rd = 5'd0;
    bus.req_wr = 1'b0; bus.rsp_ready = 1'b0; bus.wb_valid = 1'b0; bus.wb_rd = 5'd0;
    bus.wb_data = 32'h0;
    repeat (3) tick();
    tests++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %0b want 0", bus.rsp_valid); end
    tests++; if (bus.rsp_op1 !== 32'h0 || bus.rsp_op2 !== 32'h0) begin fails++; $display("FAIL reset_ops got %h/%h want 0/0", bus.rsp_op1, bus.rsp_op2); end
    tests++; if (bus.wb_err !== 1'b0) begin fails++; $display("FAIL reset_wb_err got %0b want 0", bus.wb_err); end
    tests++; if (rf_a1 !== 5'd0 || rf_a2 !== 5'd0) begin fails++; $display("FAIL reset_rf_addr got %0d/%0d want 0/0", rf_a1, rf_a2); end
    tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %0b want 1", bus.req_ready); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_zero_read();
    bus.req_rs1 = 5'd0; bus.req_rs2 = 5'd0; bus.req_rd = 5'd0; bus.req_wr = 1'b0;
    bus.req_valid = 1'b1;
    #1;
    tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL zero_req_ready got %0b want 1", bus.req_ready); end
    tick();
    bus.req_valid = 1'b0;
    tests++; if (bus.rsp_valid !== 1'b0 || rf_we !== 1'b0) begin fails++; $display("FAIL zero_read_cycle rsp_valid/rf_we got %0b/%0b want 0/0", bus.rsp_valid, rf_we); end
    tick();
    tests++; if (bus.rsp_valid !== 1'b1) begin fails++; $display("FAIL zero_latency rsp_valid got %0b want 1", bus.rsp_valid); end
    tests++; if (bus.rsp_op1 !== 32'h0 || bus.rsp_op2 !== 32'h0) begin fails++; $display("FAIL zero_ops got %h/%h want 0/0", bus.rsp_op1, bus.rsp_op2); end
    tests++; if (bus.req_ready !== 1'b0 || rf_we !== 1'b0) begin fails++; $display("FAIL zero_resp req_ready/rf_we got %0b/%0b want 0/0", bus.req_ready, rf_we); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    tests++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL zero_done rsp_valid got %0b want 0", bus.rsp_valid); end
  endtask

  task automatic test_wb_read();
    logic [31:0] o1, o2;
    bit ok;
    run_req(5'd0, 5'd0, 5'd5, 1'b1, o1, o2, ok);
    do_wb(5'd5, 32'hDEADBEEF);
    tests++; if (bus.wb_err !== 1'b0) begin fails++; $display("FAIL wbread_wb_err got %0b want 0", bus.wb_err); end
    run_req(5'd5, 5'd0, 5'd0, 1'b0, o1, o2, ok);
    tests++; if (!ok || o1 !== 32'hDEADBEEF || o2 !== 32'h0) begin fails++; $display("FAIL wbread_ops ok=%0b got %h/%h want deadbeef/0", ok, o1, o2); end
  endtask

  task automatic test_raw_stall();
    logic [31:0] o1, o2;
    bit ok;
    run_req(5'd0, 5'd0, 5'd7, 1'b1, o1, o2, ok);
    tests++; if (!ok) begin fails++; $display("FAIL raw_first_req got %0b want 1", ok); end
    bus.req_rs1 = 5'd0; bus.req_rs2 = 5'd0; bus.req_rd = 5'd7; bus.req_wr = 1'b1;
    #1;
    tests++; if (bus.req_ready !== 1'b0) begin fails++; $display("FAIL waw_hold req_ready got %0b want 0", bus.req_ready); end
    bus.req_wr = 1'b0;
    #1;
    tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL waw_nowr req_ready got %0b want 1", bus.req_ready); end
    bus.req_rs1 = 5'd7; bus.req_rd = 5'd0; bus.req_valid = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      tests++; if (bus.req_ready !== 1'b0) begin fails++; $display("FAIL raw_hold cyc%0d req_ready got %0b want 0", i, bus.req_ready); end
      tick();
    end
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = 32'h12;
    #1;
    tests++; if (bus.req_ready !== 1'b0) begin fails++; $display("FAIL raw_same_cycle req_ready got %0b want 0", bus.req_ready); end
    tick();
    bus.wb_valid = 1'b0;
    #1;
    tests++; if (bus.req_ready !== 1'b1 || bus.wb_err !== 1'b0) begin fails++; $display("FAIL raw_release req_ready/wb_err got %0b/%0b want 1/0", bus.req_ready, bus.wb_err); end
    tick();
    bus.req_valid = 1'b0;
    tick();
    tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_op1 !== 32'h12) begin fails++; $display("FAIL raw_op1 valid=%0b got %h want 12", bus.rsp_valid, bus.rsp_op1); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_forward();
    logic [31:0] o1, o2;
    bit ok;
    run_req(5'd0, 5'd0, 5'd3, 1'b1, o1, o2, ok);
    do_wb(5'd3, 32'h11);
    bus.req_rs1 = 5'd3; bus.req_rs2 = 5'd0; bus.req_rd = 5'd3; bus.req_wr = 1'b1;
    bus.req_valid = 1'b1;
    #1;
    tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL fwd_accept req_ready got %0b want 1", bus.req_ready); end
    tick();
    bus.req_valid = 1'b0; bus.req_wr = 1'b0;
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd3; bus.wb_data = 32'hA5;
    tick();
    bus.wb_valid = 1'b0;
    tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_op1 !== 32'hA5) begin fails++; $display("FAIL fwd_op1 valid=%0b got %h want a5", bus.rsp_valid, bus.rsp_op1); end
    tests++; if (bus.wb_err !== 1'b0) begin fails++; $display("FAIL fwd_wb_err got %0b want 0", bus.wb_err); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_wb_err();
    logic [31:0] o1, o2;
    bit ok;
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd9; bus.wb_data = 32'h99;
    #1;
    tests++; if (rf_we !== 1'b1 || rf_a3 !== 5'd9 || rf_wd3 !== 32'h99) begin fails++; $display("FAIL wberr_port we/a3/wd3 got %0b/%0d/%h want 1/9/99", rf_we, rf_a3, rf_wd3); end
    tick();
    bus.wb_valid = 1'b0;
    tests++; if (bus.wb_err !== 1'b1) begin fails++; $display("FAIL wberr_pulse got %0b want 1", bus.wb_err); end
    tick();
    tests++; if (bus.wb_err !== 1'b0) begin fails++; $display("FAIL wberr_clear got %0b want 0", bus.wb_err); end
    run_req(5'd9, 5'd9, 5'd0, 1'b0, o1, o2, ok);
    tests++; if (!ok || o1 !== 32'h99 || o2 !== 32'h99) begin fails++; $display("FAIL wberr_read ok=%0b got %h/%h want 99/99", ok, o1, o2); end
  endtask

  task automatic test_stall_hold();
    bus.req_rs1 = 5'd5; bus.req_rs2 = 5'd9; bus.req_rd = 5'd0; bus.req_wr = 1'b0;
    bus.req_valid = 1'b1;
    #1;
    tick();
    bus.req_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_op1 !== 32'hDEADBEEF || bus.rsp_op2 !== 32'h99 || bus.req_ready !== 1'b0) begin
        fails++;
        $display("FAIL hold cyc%0d valid/op1/op2/req_ready got %0b/%h/%h/%0b want 1/deadbeef/99/0", i, bus.rsp_valid, bus.rsp_op1, bus.rsp_op2, bus.req_ready);
      end
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    tests++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin fails++; $display("FAIL hold_done valid/req_ready got %0b/%0b want 0/1", bus.rsp_valid, bus.req_ready); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] o1, o2;
    bit ok;
    run_req(5'd0, 5'd0, 5'd11, 1'b1, o1, o2, ok);
    bus.req_rs1 = 5'd5; bus.req_rs2 = 5'd0; bus.req_rd = 5'd0; bus.req_wr = 1'b0;
    bus.req_valid = 1'b1;
    #1;
    tick();
    bus.req_valid = 1'b0;
    rst = 1'b0;
    #1;
    tests++; if (bus.rsp_valid !== 1'b0 || rf_a1 !== 5'd0) begin fails++; $display("FAIL midrst_abort valid/rf_a1 got %0b/%0d want 0/0", bus.rsp_valid, rf_a1); end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL midrst_norsp cyc%0d got %0b want 0", i, bus.rsp_valid); end
    end
    bus.req_rs1 = 5'd11; bus.req_rd = 5'd11; bus.req_wr = 1'b1;
    #1;
    tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL midrst_busy_clear req_ready got %0b want 1", bus.req_ready); end
    bus.req_wr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_read();
    test_wb_read();
    test_raw_stall();
    test_forward();
    test_wb_err();
    test_stall_hold();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
